hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Parametrised successor to the pipeline hazard unit for the 5-stage RV32IM core.
- Generalises forwarding and load-use detection to NUM_SRC register-read ports, each with a per-port "used" mask.
- Adds an internal multi-cycle FSM for mul/div in the execute stage, with independent parametrised latencies. This replaces the external done handshake.
- Adds saturating stall/flush performance counters. Sits beside the datapath; drives all stage stall/flush and forward-mux selects.

Parameters:
- RF_WIDTH, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction.
- MUL_LATENCY, 1, extra execute cycles for a multiply; 0 means single-cycle.
- DIV_LATENCY, 32, extra execute cycles for a divide/remainder; 0 means single-cycle.
- LOAD_SEL, 2'b01, resultSel encoding that marks a load.
- PERF_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- srcAddrD  in  NUM_SRC*RF_WIDTH  decode-stage source addresses; port i is bits [i*RF_WIDTH +: RF_WIDTH].
- srcUsedD  in  NUM_SRC  decode-stage source-valid mask.
- srcAddrE  in  NUM_SRC*RF_WIDTH  execute-stage source addresses.
- regAddr3E, regAddr3M, regAddr3W  in  RF_WIDTH each  destination addresses for E, M, W.
- regWriteE, regWriteM, regWriteW  in  1 each  write enables for E, M, W.
- resultSelE  in  2  result select of the instruction in E.
- pcSelE  in  2  nonzero means a redirect (taken branch or jump) resolved in E.
- isMulE  in  1  E holds MUL/MULH*.
- isDivE  in  1  E holds DIV*/REM*.
- mdAbort  in  1  trap/kill; aborts any multi-cycle op.
- stallF, stallD, stallE, stallM, stallW  out  1 each  stage stalls.
- flushD, flushE  out  1 each  stage flushes.
- forwardE  out  2*NUM_SRC  forward select per port: 00 = regfile, 10 = M, 01 = W.
- mdBusy  out  1  FSM in BUSY.
- mdDone  out  1  final cycle of a multi-cycle op.
- stallCount  out  PERF_WIDTH  cycles with stallF high.
- flushCount  out  PERF_WIDTH  cycles with flushD high.

Behaviour:
- Reset: the FSM goes to IDLE, the counter cnt to 0, and both performance counters to 0, asynchronously on rst_n low. All outputs derived from that state are then 0: every stall, every flush, every forwardE, mdBusy and mdDone.
- Multi-cycle op detect: mdReq = isDivE | isMulE. LAT is DIV_LATENCY when isDivE=1, otherwise MUL_LATENCY. Divide wins if both are high. When LAT=0 the op is ignored by the FSM.
- State IDLE:
  - If mdReq and LAT>0 and !mdAbort: set mdStall=1, load cnt=LAT-1, go to BUSY.
  - If LAT=1, cnt is loaded with 0.
- State BUSY:
  - mdStall = (cnt!=0). cnt decrements while it is nonzero.
  - When cnt==0: mdStall=0, mdDone=1, next state IDLE.
  - Net effect: exactly LAT stall cycles; the op occupies E for LAT+1 cycles.
- mdAbort: in any state, forces IDLE and cnt=0 on the next edge, and forces mdStall=0 in the same cycle.
- Load-use: loadUse is 1 when, for any port i, srcUsedD[i] & srcAddrD_i==regAddr3E & regAddr3E!=0 & regWriteE & resultSelE==LOAD_SEL.
- Stall/flush equations:
  - stallE = stallM = mdStall.
  - stallF = stallD = loadUse | mdStall.
  - stallW = 0.
  - flushD = (pcSelE!=0) & !mdStall.
  - flushE = (flushD | loadUse) & !mdStall.
  - A bubble is never injected into E while a mul/div is held there. A redirect and a load-use in the same cycle both flush E; the redirect also flushes D.
- Forwarding, per port i, evaluated independently:
  - 10 if srcAddrE_i==regAddr3M & regWriteM & srcAddrE_i!=0.
  - else 01 if srcAddrE_i==regAddr3W & regWriteW & srcAddrE_i!=0.
  - else 00.
  - M has priority over W. x0 never forwards.
- Performance counters: stallCount increments each cycle stallF=1, and flushCount each cycle flushD=1. Both saturate at 2^PERF_WIDTH-1 and never wrap.
- Back-to-back ops: a new mul/div arriving in E in the cycle after mdDone restarts from IDLE with no gap cycle.

Test Plan:
- Load-use: lw x5 in E (resultSelE=01, regWriteE=1, regAddr3E=5), srcAddrD port0=5, srcUsedD=01 -> stallF=stallD=flushE=1 for 1 cycle. Repeat with srcUsedD=00 -> no stall. Repeat with regAddr3E=0 -> no stall.
- Divide, DIV_LATENCY=32: isDivE held -> stallE=stallM=stallF=1 for exactly 32 cycles, mdBusy high for cycles 2..33, mdDone=1 in cycle 33 with all stalls 0. stallCount=32.
- Abort: div in BUSY at cnt=10, mdAbort pulsed -> stalls drop the same cycle, state IDLE next cycle, mdDone never asserted.
- Simultaneous events: during BUSY drive pcSelE=2'b01 and a D-stage load-use match -> flushD=flushE=0, stallF=1. After release, pcSelE=01 -> flushD=flushE=1, flushCount increments.
- Forwarding, NUM_SRC=3: port0=7 with M and W both writing x7 -> 10. Port1=9 with W only writing x9 -> 01. Port2=0 with M writing x0 -> 00.
- Reset mid-op: rst_n low asynchronously during BUSY with MUL_LATENCY=4 -> all outputs 0 immediately, counters cleared. After release with isMulE=0 -> IDLE, no stall.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: N-port forwarding, load-use detection, internal mul/div
// multi-cycle sequencer and saturating stall/flush performance counters.
module hazard_unit_mc #(
  parameter int          RF_WIDTH    = 5,
  parameter int          NUM_SRC     = 2,
  parameter int          MUL_LATENCY = 1,
  parameter int          DIV_LATENCY = 32,
  parameter logic [1:0]  LOAD_SEL    = 2'b01,
  parameter int          PERF_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC*RF_WIDTH-1:0]  srcAddrD,
  input  logic [NUM_SRC-1:0]           srcUsedD,
  input  logic [NUM_SRC*RF_WIDTH-1:0]  srcAddrE,
  input  logic [RF_WIDTH-1:0]          regAddr3E,
  input  logic [RF_WIDTH-1:0]          regAddr3M,
  input  logic [RF_WIDTH-1:0]          regAddr3W,
  input  logic                         regWriteE,
  input  logic                         regWriteM,
  input  logic                         regWriteW,
  input  logic [1:0]                   resultSelE,
  input  logic [1:0]                   pcSelE,
  input  logic                         isMulE,
  input  logic                         isDivE,
  input  logic                         mdAbort,
  output logic                         stallF,
  output logic                         stallD,
  output logic                         stallE,
  output logic                         stallM,
  output logic                         stallW,
  output logic                         flushD,
  output logic                         flushE,
  output logic [2*NUM_SRC-1:0]         forwardE,
  output logic                         mdBusy,
  output logic                         mdDone,
  output logic [PERF_WIDTH-1:0]        stallCount,
  output logic [PERF_WIDTH-1:0]        flushCount
);

  localparam int MAX_LAT = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LATENCY);
  localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_lat;
  logic                  w_md_req;
  logic                  w_md_stall;
  logic                  w_md_done;
  logic                  w_lu_hit;
  logic                  w_load_use;
  logic                  w_flush_d;
  logic [2*NUM_SRC-1:0]  w_fwd;
  logic [PERF_WIDTH-1:0] r_stall_cnt;
  logic [PERF_WIDTH-1:0] r_flush_cnt;

  // Divide takes precedence when both op flags are raised.
  assign w_md_req = isDivE | isMulE;
  assign w_lat    = isDivE ? DIV_LAT_C : MUL_LAT_C;

  // Mul/div sequencer: stall LAT cycles, then one done cycle with E released.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_md_stall  = 1'b0;
    w_md_done   = 1'b0;
    if (mdAbort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_md_req && (w_lat != CNT_ZERO)) begin
            w_md_stall  = 1'b1;
            w_cnt_nxt   = w_lat - CNT_ONE;
            w_state_nxt = S_BUSY;
          end else begin
            w_cnt_nxt   = CNT_ZERO;
          end
        end
        S_BUSY: begin
          if (r_cnt != CNT_ZERO) begin
            w_md_stall = 1'b1;
            w_cnt_nxt  = r_cnt - CNT_ONE;
          end else begin
            w_md_done   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // Sequencer state and countdown register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Any used decode source matching the E destination.
  always_comb begin
    w_lu_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (srcUsedD[i] && (srcAddrD[i*RF_WIDTH +: RF_WIDTH] == regAddr3E)) begin
        w_lu_hit = 1'b1;
      end else begin
        w_lu_hit = w_lu_hit;
      end
    end
  end

  assign w_load_use = w_lu_hit & regWriteE & (regAddr3E != {RF_WIDTH{1'b0}})
                    & (resultSelE == LOAD_SEL);

  // Per-port forward select; M beats W and x0 never forwards.
  always_comb begin
    w_fwd = {(2*NUM_SRC){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (regWriteM && (srcAddrE[i*RF_WIDTH +: RF_WIDTH] == regAddr3M)
          && (srcAddrE[i*RF_WIDTH +: RF_WIDTH] != {RF_WIDTH{1'b0}})) begin
        w_fwd[2*i +: 2] = 2'b10;
      end else if (regWriteW && (srcAddrE[i*RF_WIDTH +: RF_WIDTH] == regAddr3W)
          && (srcAddrE[i*RF_WIDTH +: RF_WIDTH] != {RF_WIDTH{1'b0}})) begin
        w_fwd[2*i +: 2] = 2'b01;
      end else begin
        w_fwd[2*i +: 2] = 2'b00;
      end
    end
  end

  // Outputs are held quiet for the whole time reset is asserted.
  assign w_flush_d = (pcSelE != 2'b00) & ~w_md_stall;
  assign stallE    = rst_n & w_md_stall;
  assign stallM    = rst_n & w_md_stall;
  assign stallF    = rst_n & (w_load_use | w_md_stall);
  assign stallD    = rst_n & (w_load_use | w_md_stall);
  assign stallW    = 1'b0;
  assign flushD    = rst_n & w_flush_d;
  assign flushE    = rst_n & (w_flush_d | w_load_use) & ~w_md_stall;
  assign forwardE  = rst_n ? w_fwd : {(2*NUM_SRC){1'b0}};
  assign mdBusy    = rst_n & (r_state == S_BUSY);
  assign mdDone    = rst_n & w_md_done;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {PERF_WIDTH{1'b0}};
      r_flush_cnt <= {PERF_WIDTH{1'b0}};
    end else begin
      if (stallF && (r_stall_cnt != {PERF_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (flushD && (r_flush_cnt != {PERF_WIDTH{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign stallCount = r_stall_cnt;
  assign flushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc with a queue scoreboard; a second instance
// with 2-bit counters exercises counter saturation on the same stimulus.
module tb_hazard_unit_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] srcAddrD, srcAddrE;
  logic [2:0]  srcUsedD;
  logic [4:0]  regAddr3E, regAddr3M, regAddr3W;
  logic        regWriteE, regWriteM, regWriteW;
  logic [1:0]  resultSelE, pcSelE;
  logic        isMulE, isDivE, mdAbort;

  logic        stallF, stallD, stallE, stallM, stallW, flushD, flushE, mdBusy, mdDone;
  logic [5:0]  forwardE;
  logic [31:0] stallCount, flushCount;

  logic        s_stallF, s_stallD, s_stallE, s_stallM, s_stallW, s_flushD, s_flushE;
  logic        s_mdBusy, s_mdDone;
  logic [5:0]  s_forwardE;
  logic [1:0]  s_stallCount, s_flushCount;

  always #5 clk = ~clk;

  hazard_unit_mc #(.RF_WIDTH(5), .NUM_SRC(3), .MUL_LATENCY(4), .DIV_LATENCY(32),
                   .LOAD_SEL(2'b01), .PERF_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .srcAddrD(srcAddrD), .srcUsedD(srcUsedD),
    .srcAddrE(srcAddrE), .regAddr3E(regAddr3E), .regAddr3M(regAddr3M),
    .regAddr3W(regAddr3W), .regWriteE(regWriteE), .regWriteM(regWriteM),
    .regWriteW(regWriteW), .resultSelE(resultSelE), .pcSelE(pcSelE),
    .isMulE(isMulE), .isDivE(isDivE), .mdAbort(mdAbort),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .stallW(stallW), .flushD(flushD), .flushE(flushE), .forwardE(forwardE),
    .mdBusy(mdBusy), .mdDone(mdDone), .stallCount(stallCount), .flushCount(flushCount)
  );

  hazard_unit_mc #(.RF_WIDTH(5), .NUM_SRC(3), .MUL_LATENCY(4), .DIV_LATENCY(32),
                   .LOAD_SEL(2'b01), .PERF_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .srcAddrD(srcAddrD), .srcUsedD(srcUsedD),
    .srcAddrE(srcAddrE), .regAddr3E(regAddr3E), .regAddr3M(regAddr3M),
    .regAddr3W(regAddr3W), .regWriteE(regWriteE), .regWriteM(regWriteM),
    .regWriteW(regWriteW), .resultSelE(resultSelE), .pcSelE(pcSelE),
    .isMulE(isMulE), .isDivE(isDivE), .mdAbort(mdAbort),
    .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE), .stallM(s_stallM),
    .stallW(s_stallW), .flushD(s_flushD), .flushE(s_flushE), .forwardE(s_forwardE),
    .mdBusy(s_mdBusy), .mdDone(s_mdDone), .stallCount(s_stallCount),
    .flushCount(s_flushCount)
  );

  typedef struct {
    logic [8:0]  ctl;
    logic [5:0]  fwd;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [95:0] tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_sc = 0;
  int exp_fc = 0;

  // ctl bit order: stallF stallD stallE stallM stallW flushD flushE mdBusy mdDone
  localparam logic [8:0] C0     = 9'b000000000;
  localparam logic [8:0] C_LU   = 9'b110000100;
  localparam logic [8:0] C_FL   = 9'b000001100;
  localparam logic [8:0] C_LUFL = 9'b110001100;
  localparam logic [8:0] C_MD0  = 9'b111100000;
  localparam logic [8:0] C_MD   = 9'b111100010;
  localparam logic [8:0] C_DONE = 9'b000000011;
  localparam logic [8:0] C_ABT  = 9'b000000010;

  task automatic clear_inputs();
    srcAddrD = 15'd0; srcAddrE = 15'd0; srcUsedD = 3'b000;
    regAddr3E = 5'd0; regAddr3M = 5'd0; regAddr3W = 5'd0;
    regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
    resultSelE = 2'b00; pcSelE = 2'b00;
    isMulE = 1'b0; isDivE = 1'b0; mdAbort = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] dst, input logic [14:0] srcs,
                              input logic [2:0] used);
    regWriteE = 1'b1; resultSelE = 2'b01; regAddr3E = dst;
    srcAddrD = srcs; srcUsedD = used;
  endtask

  task automatic cyc(input logic [8:0] ce, input logic [5:0] fe, input logic [95:0] tag);
    exp_t e;
    logic [8:0] obs;
    logic [1:0] sat_sc, sat_fc;
    e.ctl = ce; e.fwd = fe; e.sc = exp_sc; e.fc = exp_fc; e.tag = tag;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    obs = {stallF, stallD, stallE, stallM, stallW, flushD, flushE, mdBusy, mdDone};
    sat_sc = (e.sc > 32'd3) ? 2'd3 : e.sc[1:0];
    sat_fc = (e.fc > 32'd3) ? 2'd3 : e.fc[1:0];
    checks++;
    assert (obs === e.ctl) else begin
      errors++; $error("FAIL %0s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
    end
    checks++;
    assert (forwardE === e.fwd) else begin
      errors++; $error("FAIL %0s forwardE observed=%b expected=%b", e.tag, forwardE, e.fwd);
    end
    checks++;
    assert (stallCount === e.sc) else begin
      errors++; $error("FAIL %0s stallCount observed=%0d expected=%0d", e.tag, stallCount, e.sc);
    end
    checks++;
    assert (flushCount === e.fc) else begin
      errors++; $error("FAIL %0s flushCount observed=%0d expected=%0d", e.tag, flushCount, e.fc);
    end
    checks++;
    assert ({s_stallCount, s_flushCount} === {sat_sc, sat_fc}) else begin
      errors++; $error("FAIL %0s sat counters observed=%0d/%0d expected=%0d/%0d",
                       e.tag, s_stallCount, s_flushCount, sat_sc, sat_fc);
    end
    if (e.ctl[8]) exp_sc++;
    if (e.ctl[3]) exp_fc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    // forwarding match while in reset must still read as zero
    srcAddrE = {5'd0, 5'd0, 5'd7}; regAddr3M = 5'd7; regWriteM = 1'b1;
    cyc(C0, 6'b000000, "reset");
    rst_n = 1'b1;
    clear_inputs();
    cyc(C0, 6'b000000, "idle");

    set_load_use(5'd5, {5'd0, 5'd0, 5'd5}, 3'b001);
    cyc(C_LU, 6'b000000, "lu_p0");
    srcUsedD = 3'b000;
    cyc(C0, 6'b000000, "lu_unused");
    set_load_use(5'd0, {5'd0, 5'd0, 5'd0}, 3'b001);
    cyc(C0, 6'b000000, "lu_x0");
    set_load_use(5'd5, {5'd5, 5'd3, 5'd4}, 3'b100);
    cyc(C_LU, 6'b000000, "lu_p2");
    resultSelE = 2'b10;
    cyc(C0, 6'b000000, "lu_notload");
    clear_inputs();

    srcAddrE = {5'd0, 5'd9, 5'd7};
    regAddr3M = 5'd7; regWriteM = 1'b1; regAddr3W = 5'd7; regWriteW = 1'b1;
    cyc(C0, 6'b000010, "fwd_m_pri");
    regAddr3M = 5'd0; regAddr3W = 5'd9;
    cyc(C0, 6'b000100, "fwd_w_x0");
    regAddr3M = 5'd7; regWriteM = 1'b0; regAddr3W = 5'd7;
    cyc(C0, 6'b000001, "fwd_w_only");
    clear_inputs();

    pcSelE = 2'b10;
    for (int k = 0; k < 4; k++) cyc(C_FL, 6'b000000, "redirect");
    set_load_use(5'd6, {5'd0, 5'd6, 5'd0}, 3'b010);
    cyc(C_LUFL, 6'b000000, "lu_redir");
    clear_inputs();

    isDivE = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      if (k == 5) begin
        set_load_use(5'd5, {5'd0, 5'd0, 5'd5}, 3'b001);
        pcSelE = 2'b01;
      end else begin
        srcUsedD = 3'b000;
        pcSelE = 2'b00;
      end
      if (k == 1) cyc(C_MD0, 6'b000000, "div_start");
      else if (k <= 32) cyc(C_MD, 6'b000000, "div_busy");
      else cyc(C_DONE, 6'b000000, "div_done");
    end
    clear_inputs();
    cyc(C0, 6'b000000, "div_after");
    pcSelE = 2'b01;
    cyc(C_FL, 6'b000000, "redir_after");
    pcSelE = 2'b00;
    cyc(C0, 6'b000000, "quiet");

    isMulE = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 5; k++) begin
        if (k == 1) cyc(C_MD0, 6'b000000, "mul_start");
        else if (k <= 4) cyc(C_MD, 6'b000000, "mul_busy");
        else cyc(C_DONE, 6'b000000, "mul_done");
      end
    end
    isMulE = 1'b0;
    cyc(C0, 6'b000000, "mul_after");

    isDivE = 1'b1; isMulE = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      if (k == 1) cyc(C_MD0, 6'b000000, "both_start");
      else cyc(C_MD, 6'b000000, "both_busy");
    end
    mdAbort = 1'b1;
    cyc(C_ABT, 6'b000000, "abort");
    clear_inputs();
    for (int k = 0; k < 3; k++) cyc(C0, 6'b000000, "post_abort");
    isDivE = 1'b1; mdAbort = 1'b1;
    cyc(C0, 6'b000000, "abort_idle");
    clear_inputs();

    isMulE = 1'b1;
    cyc(C_MD0, 6'b000000, "mul4_start");
    cyc(C_MD, 6'b000000, "mul4_busy");
    #2;
    rst_n = 1'b0;
    exp_sc = 0; exp_fc = 0;
    srcAddrE = {5'd0, 5'd0, 5'd3}; regAddr3M = 5'd3; regWriteM = 1'b1;
    pcSelE = 2'b01;
    cyc(C0, 6'b000000, "rst_mid_op");
    rst_n = 1'b1;
    clear_inputs();
    cyc(C0, 6'b000000, "rst_release");
    pcSelE = 2'b01;
    cyc(C_FL, 6'b000000, "rst_redir");
    pcSelE = 2'b00;
    cyc(C0, 6'b000000, "rst_cnt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
